shifter_seq_n: RTL and testbench
================================

# shifter_seq_n

Parametrised sequential shift/rotate register with a start/busy/done handshake, for WIDTH-bit datapaths.
- Accepts one command per handshake: load, clear, no-op, or a multi-bit logical/arithmetic shift or rotate.
- Shifts execute one bit position per clock, so cost stays at one WIDTH-bit register plus a small counter.
- Sits beside the counter and register file as the shifting element of the datapath.

## Interface
- WIDTH, 8, data width in bits; minimum 2.
- SW (localparam), $clog2(WIDTH), shift-amount width.
- clk  input  1  clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  command strobe; sampled only when busy=0.
- op  input  3  command: 000 NOP, 001 LOAD, 010 LSL, 011 LSR, 100 ASR, 101 ROL, 110 ROR, 111 CLR.
- shamt  input  SW  shift amount 0..WIDTH-1; ignored for NOP/LOAD/CLR.
- d  input  WIDTH  load data; used only by LOAD.
- q  output  WIDTH  register contents.
- carry  output  1  last bit shifted or rotated out.
- busy  output  1  high while a multi-cycle shift is in progress.
- done  output  1  one-cycle pulse when a command completes.

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, any state): q=0, carry=0, busy=0, done=0, state=IDLE, count=0.
- Command accept: start=1 on an edge with state IDLE or DONE. In RUN, start is ignored and op/shamt/d changes have no effect.
- Single-cycle commands, applied at the accept edge, next state DONE:
  - LOAD: q=d, carry=0.
  - CLR: q=0, carry=0.
  - NOP: q and carry unchanged.
  - Any shift op with shamt=0: q and carry unchanged.
- Shift commands with shamt=k≥1:
  - Accept edge latches op and count=k, next state RUN; q is not modified on this edge.
  - Each RUN edge applies one 1-bit step and decrements count.
  - When count reaches 0 after a step, next state is DONE.
- Per-step rules:
  - LSL: q={q[W-2:0],0}, carry=q[W-1].
  - LSR: q={0,q[W-1:1]}, carry=q[0].
  - ASR: q={q[W-1],q[W-1:1]}, carry=q[0].
  - ROL: q={q[W-2:0],q[W-1]}, carry=q[W-1].
  - ROR: q={q[0],q[W-1:1]}, carry=q[0].
- DONE lasts one cycle, then IDLE unless a new start is accepted on that edge.
- Accept in DONE allows back-to-back commands with no idle gap.
- busy=1 exactly in RUN; done=1 exactly in DONE. Both are registered outputs, with no combinational path from inputs.

## Timing
- LOAD/CLR/NOP/shamt=0: q valid after the accept edge; done high the cycle after the accept edge; busy stays 0.
- Shift by k≥1:
  - busy high for k cycles after the accept edge.
  - q changes on edges 1..k after the accept edge.
  - done high on cycle k+1.
  - Total latency from accept to done is k+1 cycles.
- Throughput: one command per (k+1) cycles for shifts, one per cycle for single-cycle commands.
- q and carry hold their value when no command is active.
- Reset asserted mid-RUN aborts immediately: no done pulse, q=0. The first post-reset edge with start=1 is accepted.

## Test plan
- Reset then LOAD d=0xB5 (WIDTH=8) -> q=0xB5, carry=0, done pulse one cycle later, busy never high.
- From q=0xB5, LSL shamt=3 -> busy for 3 cycles, q steps 0x6A, 0xD4, 0xA8, carry=1, done on cycle 4.
- From q=0xB5, ASR shamt=2 -> q=0xED, carry=0. From q=0xB5, ROR shamt=4 -> q=0x5B, carry=0, latency 5 cycles.
- During an LSR shamt=7 on q=0xFF, pulse start with op=CLR at cycle 2 -> CLR ignored; final q=0x01, carry=1. Then start in the DONE cycle with LOAD 0x3C -> accepted, q=0x3C.
- Assert reset_n=0 mid-ROL between clock edges -> q, carry, busy, done go to 0 immediately, with no done pulse after release. NOP and shamt=0 shift -> q unchanged, done pulse.
- WIDTH=16: LOAD 0x8001, ROL shamt=15 -> q=0xC000, carry=0, busy for 15 cycles.

Source files
------------

// File: rtl/shifter_seq_n.sv
// shifter_seq_n: sequential shift/rotate register, one bit per clock, with start/busy/done handshake.
module shifter_seq_n #(
   parameter int WIDTH = 8,
   localparam int SW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [SW-1:0]    shamt,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             carry,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [2:0] OP_LOAD = 3'b001, OP_LSL = 3'b010, OP_LSR = 3'b011,
                          OP_ASR = 3'b100, OP_ROL = 3'b101, OP_ROR = 3'b110, OP_CLR = 3'b111;
   state_t state, state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic carry_nxt;
   logic [SW-1:0] count, count_nxt;
   logic [2:0] op_r, op_nxt;
   logic is_shift;
   assign is_shift = op >= OP_LSL && op <= OP_ROR;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         q     <= '0;
         carry <= 1'b0;
         count <= '0;
         op_r  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         q     <= q_nxt;
         carry <= carry_nxt;
         count <= count_nxt;
         op_r  <= op_nxt;
         busy  <= state_nxt == RUN;
         done  <= state_nxt == DONE;
      end
   end
   always_comb begin
      state_nxt = state;
      q_nxt     = q;
      carry_nxt = carry;
      count_nxt = count;
      op_nxt    = op_r;
      if (state == RUN) begin
         case (op_r)
            OP_LSL:  {carry_nxt, q_nxt} = {q, 1'b0};
            OP_LSR:  {q_nxt, carry_nxt} = {1'b0, q};
            OP_ASR:  {q_nxt, carry_nxt} = {q[WIDTH-1], q};
            OP_ROL:  {carry_nxt, q_nxt} = {q, q[WIDTH-1]};
            OP_ROR:  {q_nxt, carry_nxt} = {q[0], q};
            default: ;
         endcase
         count_nxt = count - SW'(1);
         if (count == SW'(1)) state_nxt = DONE;
      end else begin
         state_nxt = IDLE;
         if (start) begin
            // a shift of zero collapses into a single-cycle no-op
            if (is_shift && shamt != '0) begin
               state_nxt = RUN;
               op_nxt    = op;
               count_nxt = shamt;
            end else begin
               state_nxt = DONE;
               if (op == OP_LOAD) {q_nxt, carry_nxt} = {d, 1'b0};
               if (op == OP_CLR)  {q_nxt, carry_nxt} = '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_shifter_seq_n.sv
// tb_shifter_seq_n: directed vectors for shifter_seq_n at WIDTH=8 and WIDTH=16.
module tb_shifter_seq_n;
   logic clk = 0, reset_n = 0, start = 0;
   logic [2:0] op = 0, shamt = 0;
   logic [7:0] d = 0, q;
   logic carry, busy, done;
   logic start16 = 0;
   logic [2:0] op16 = 0;
   logic [3:0] shamt16 = 0;
   logic [15:0] d16 = 0, q16;
   logic carry16, busy16, done16;
   int total = 0, bad = 0;
   int lat, bc, n, dc;
   shifter_seq_n #(.WIDTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .shamt(shamt), .d(d),
      .q(q), .carry(carry), .busy(busy), .done(done)
   );
   shifter_seq_n #(.WIDTH(16)) dut16 (
      .clk(clk), .reset_n(reset_n), .start(start16), .op(op16), .shamt(shamt16), .d(d16),
      .q(q16), .carry(carry16), .busy(busy16), .done(done16)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   // issues one command and returns accept-to-done latency and busy-cycle count
   task automatic cmd(input logic [2:0] o, input logic [2:0] s, input logic [7:0] dv,
                      output int l, output int b);
      start = 1; op = o; shamt = s; d = dv;
      cyc();
      start = 0; l = 1; b = 0;
      while (!done && l < 20) begin
         b += int'(busy);
         cyc();
         l++;
      end
      check("done_seen", {31'd0, done}, 1);
   endtask
   initial begin
      #12;
      check("rst_q", q, 0);
      check("rst_carry", carry, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(negedge clk) reset_n = 1;
      cyc();
      cmd(3'd1, 0, 8'hB5, lat, bc);
      check("load_q", q, 8'hB5);
      check("load_carry", carry, 0);
      check("load_lat", lat, 1);
      check("load_busy", bc, 0);
      start = 1; op = 3'd2; shamt = 3;
      cyc();
      start = 0;
      check("lsl_acc_q", q, 8'hB5);
      check("lsl_acc_busy", busy, 1);
      cyc();
      check("lsl_s1_q", q, 8'h6A);
      check("lsl_s1_c", carry, 1);
      cyc();
      check("lsl_s2_q", q, 8'hD4);
      check("lsl_s2_c", carry, 0);
      check("lsl_s2_busy", busy, 1);
      cyc();
      check("lsl_s3_q", q, 8'hA8);
      check("lsl_s3_c", carry, 1);
      check("lsl_s3_busy", busy, 0);
      check("lsl_done", done, 1);
      cyc();
      check("idle_done", done, 0);
      cmd(3'd1, 0, 8'hB5, lat, bc);
      cmd(3'd4, 2, 0, lat, bc);
      check("asr_q", q, 8'hED);
      check("asr_c", carry, 0);
      check("asr_lat", lat, 3);
      cmd(3'd1, 0, 8'hB5, lat, bc);
      cmd(3'd6, 4, 0, lat, bc);
      check("ror_q", q, 8'h5B);
      check("ror_c", carry, 0);
      check("ror_lat", lat, 5);
      check("ror_busy", bc, 4);
      cmd(3'd1, 0, 8'hFF, lat, bc);
      start = 1; op = 3'd3; shamt = 7;
      cyc();
      start = 0;
      cyc();
      start = 1; op = 3'd7;
      cyc();
      start = 0; n = 0;
      while (!done && n < 20) begin
         cyc();
         n++;
      end
      check("lsr_done", done, 1);
      check("lsr_q", q, 8'h01);
      check("lsr_c", carry, 1);
      cmd(3'd1, 0, 8'h3C, lat, bc);
      check("b2b_q", q, 8'h3C);
      check("b2b_lat", lat, 1);
      cmd(3'd1, 0, 8'h81, lat, bc);
      start = 1; op = 3'd5; shamt = 5;
      cyc();
      start = 0;
      cyc();
      check("rol_pre_q", q, 8'h03);
      check("rol_pre_c", carry, 1);
      #2 reset_n = 0;
      #1;
      check("arst_q", q, 0);
      check("arst_carry", carry, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      @(posedge clk);
      @(negedge clk) reset_n = 1;
      dc = 0;
      repeat (8) begin
         cyc();
         dc += int'(done);
      end
      check("arst_no_done", dc, 0);
      check("arst_q_hold", q, 0);
      cmd(3'd1, 0, 8'h5B, lat, bc);
      check("post_rst_load", q, 8'h5B);
      cmd(3'd6, 1, 0, lat, bc);
      check("ror1_q", q, 8'hAD);
      check("ror1_c", carry, 1);
      cmd(3'd0, 0, 0, lat, bc);
      check("nop_q", q, 8'hAD);
      check("nop_c", carry, 1);
      check("nop_lat", lat, 1);
      cmd(3'd2, 0, 0, lat, bc);
      check("sh0_q", q, 8'hAD);
      check("sh0_c", carry, 1);
      check("sh0_lat", lat, 1);
      check("sh0_busy", bc, 0);
      cyc();
      start16 = 1; op16 = 3'd1; d16 = 16'h8001;
      cyc();
      start16 = 0;
      check("w16_load_q", q16, 16'h8001);
      check("w16_load_done", done16, 1);
      start16 = 1; op16 = 3'd5; shamt16 = 15;
      cyc();
      start16 = 0; n = 1; bc = 0;
      while (!done16 && n < 40) begin
         bc += int'(busy16);
         cyc();
         n++;
      end
      check("w16_done", done16, 1);
      check("w16_q", q16, 16'hC000);
      check("w16_c", carry16, 0);
      check("w16_busy", bc, 15);
      check("w16_lat", n, 16);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
